// File: rtl/imm_materializer_if.sv
// Request/instruction handshake bundle between the program generator,
// the immediate materialiser and the instruction-memory write port.
interface imm_materializer_if #(
    parameter int DATA_WIDTH = 32
);
    // Request side: constant and destination register
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_value;
    logic [4:0]            in_rd;

    // Instruction side: one encoded RV32I word per transfer
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_instr;
    logic                  out_last;

    // Generator / memory-writer view
    modport master (
        output in_valid,
        output in_value,
        output in_rd,
        input  in_ready,
        input  out_valid,
        input  out_instr,
        input  out_last,
        output out_ready
    );

    // Materialiser view
    modport slave (
        input  in_valid,
        input  in_value,
        input  in_rd,
        output in_ready,
        output out_valid,
        output out_instr,
        output out_last,
        input  out_ready
    );
endinterface

// File: rtl/imm_materializer.sv
// Turns a 32-bit constant plus destination register into the shortest
// RV32I sequence that rebuilds it: ADDI alone, LUI alone, or LUI+ADDI.
// One request in flight at a time; words drain under valid/ready.
// Only DATA_WIDTH = 32 is meaningful (RV32I encodings).
module imm_materializer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    imm_materializer_if.slave     bus
);

    localparam logic [6:0]  OPC_LUI  = 7'b0110111;
    localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
    localparam logic [2:0]  F3_ADDI  = 3'b000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT1,
        ST_EMIT2
    } state_t;

    state_t                r_state;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_instr;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_second;

    logic [11:0]           w_lo;
    logic [19:0]           w_hi;
    logic                  w_fits12;
    logic                  w_rd_zero;
    logic [DATA_WIDTH-1:0] w_lui;
    logic [DATA_WIDTH-1:0] w_addi_x0;
    logic [DATA_WIDTH-1:0] w_addi_rd;
    logic [DATA_WIDTH-1:0] w_first;
    logic [DATA_WIDTH-1:0] w_second;
    logic                  w_single;
    logic                  w_accept;

    // Ready only when idle and never while reset is being applied.
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign bus.in_ready = (r_state == ST_IDLE) && !rst;

    // Split the incoming constant and pre-encode both candidate words.
    // NOTE: every output gets a default first so no latch can be inferred.
    always_comb begin
        w_lo      = bus.in_value[11:0];
        // ADDI sign-extends lo, so the upper part is rounded up when bit 11
        // is set; the 20-bit add wraps on purpose (0x7FFFF800 -> hi=0x80000).
        w_hi      = bus.in_value[31:12] + {19'd0, bus.in_value[11]};
        w_fits12  = (&bus.in_value[31:11]) || !(|bus.in_value[31:11]);
        w_rd_zero = (bus.in_rd == 5'd0);

        w_lui     = {w_hi, bus.in_rd, OPC_LUI};
        w_addi_x0 = {w_lo, 5'd0, F3_ADDI, bus.in_rd, OPC_OPIMM};
        w_addi_rd = {w_lo, bus.in_rd, F3_ADDI, bus.in_rd, OPC_OPIMM};

        w_first   = w_lui;
        w_second  = w_addi_rd;
        w_single  = 1'b0;

        if (w_rd_zero) begin
            // Writes to x0 are discarded anyway: emit the canonical NOP.
            w_first  = NOP_WORD;
            w_single = 1'b1;
        end else if (w_fits12) begin
            w_first  = w_addi_x0;
            w_single = 1'b1;
        end else if (w_lo == 12'd0) begin
            w_first  = w_lui;
            w_single = 1'b1;
        end
    end

    // Sequencer: load word 1 on accept, hold under backpressure, then
    // either finish or swap in the buffered ADDI.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_last  <= 1'b0;
            r_second    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_EMIT1;
                        r_out_valid <= 1'b1;
                        r_out_instr <= w_first;
                        r_out_last  <= w_single;
                        r_second    <= w_second;
                    end
                end
                ST_EMIT1: begin
                    if (bus.out_ready) begin
                        if (r_out_last) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= ST_EMIT2;
                            r_out_instr <= r_second;
                            r_out_last  <= 1'b1;
                        end
                    end
                end
                ST_EMIT2: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_imm_materializer.sv
// Self-checking bench for imm_materializer: directed test-plan cases,
// mid-sequence reset, then randomized constants against a reference model.
module tb_imm_materializer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    imm_materializer_if #(.DATA_WIDTH(32)) bus ();

    imm_materializer #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: value -> word list, straight from the arithmetic rules.
    function automatic void model(input logic [31:0] v, input logic [4:0] rd,
                                  output int n, output logic [31:0] w0,
                                  output logic [31:0] w1);
        int signed   sv;
        logic [31:0] hi;
        logic [31:0] lo;
        sv = $signed(v);
        hi = (v + 32'h800) >> 12;
        lo = v & 32'hFFF;
        w1 = 32'h0;
        if (rd == 5'd0) begin
            n  = 1;
            w0 = 32'h0000_0013;
        end else if (sv >= -2048 && sv <= 2047) begin
            n  = 1;
            w0 = (lo << 20) | (32'(rd) << 7) | 32'h13;
        end else if (lo == 0) begin
            n  = 1;
            w0 = (hi << 12) | (32'(rd) << 7) | 32'h37;
        end else begin
            n  = 2;
            w0 = (hi << 12) | (32'(rd) << 7) | 32'h37;
            w1 = (lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
        end
    endfunction

    // Executes one emitted word on a one-register machine.
    function automatic logic [31:0] execute(input logic [31:0] w, input logic [31:0] acc);
        logic [31:0] base;
        if (w[6:0] == 7'h37) begin
            return {w[31:12], 12'h000};
        end
        base = (w[19:15] == 5'd0) ? 32'h0 : acc;
        return base + {{20{w[31]}}, w[31:20]};
    endfunction

    task automatic run_txn(input logic [31:0] v, input logic [4:0] rd, input int stall);
        int          n;
        int          waited;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_w [2];
        logic [31:0] acc;
        model(v, rd, n, w0, w1);
        exp_w[0] = w0;
        exp_w[1] = w1;
        waited = 0;
        while (!bus.in_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_rd    = rd;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_value = $urandom;
        bus.in_rd    = 5'($urandom);
        acc = 32'h0;
        for (int i = 0; i < n; i++) begin
            check("out_valid", 32'(bus.out_valid), 32'd1);
            check("out_instr", bus.out_instr, exp_w[i]);
            check("out_last", 32'(bus.out_last), 32'(i == n - 1));
            check("in_ready_busy", 32'(bus.in_ready), 32'd0);
            check("rd_field", 32'(bus.out_instr[11:7]), 32'(rd));
            acc = execute(bus.out_instr, acc);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_instr", bus.out_instr, exp_w[i]);
                check("hold_last", 32'(bus.out_last), 32'(i == n - 1));
                check("hold_ready", 32'(bus.in_ready), 32'd0);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        check("out_valid_done", 32'(bus.out_valid), 32'd0);
        if (rd != 5'd0) check("rebuilt_value", acc, v);
    endtask

    function automatic logic [31:0] rand_value();
        logic [31:0] edges [8];
        edges = '{32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F800, 32'hFFFF_F7FF,
                  32'h7FFF_F800, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 4095)) - 32'd2048;
            2:       return $urandom & 32'hFFFF_F000;
            3:       return edges[$urandom_range(0, 7)];
            default: return ($urandom & 32'hFFFF_F000) | 32'h800 | ($urandom & 32'h7FF);
        endcase
    endfunction

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_value  = 32'h0000_0005;
        bus.in_rd     = 5'd1;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_txn(32'h0000_0005, 5'd1, 0);
        run_txn(32'hFFFF_FFFF, 5'd2, 1);
        run_txn(32'h1234_5678, 5'd5, 0);
        run_txn(32'h1234_5678, 5'd5, 3);
        run_txn(32'h0000_0800, 5'd3, 0);
        run_txn(32'h7FFF_F800, 5'd3, 2);
        run_txn(32'h0001_0000, 5'd4, 0);
        run_txn(32'h1234_5678, 5'd0, 1);

        // Reset in the middle of a two-word sequence
        bus.in_valid = 1'b1;
        bus.in_value = 32'h1234_5678;
        bus.in_rd    = 5'd5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mr_valid", 32'(bus.out_valid), 32'd1);
        check("mr_word1", bus.out_instr, 32'h1234_52B7);
        rst = 1'b1;
        @(negedge clk);
        check("mr_flush", 32'(bus.out_valid), 32'd0);
        check("mr_ready_in_rst", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mr_ready_after", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mr_no_word2", 32'(bus.out_valid), 32'd0);
        end
        bus.out_ready = 1'b0;
        run_txn(32'h0000_0800, 5'd7, 0);

        // Randomized constants, registers and stalls
        for (int t = 0; t < 300; t++) begin
            run_txn(rand_value(), 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
